// File: rtl/frame_sequencer.sv
// Frame-level controller for the GPU clock domain: periodic framebuffer swap/clear
// pulses, per-frame matrix load / vertex-fetch release sequencing and frame statistics.
module frame_sequencer #(
  parameter int FRAME_PERIOD   = 2_000_000,
  parameter int TIMER_WIDTH    = 22,
  parameter int MATRIX_LATENCY = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic        framebuffer_ready_in,
  input  logic        pixel_valid_in,
  input  logic        pipeline_idle_in,
  output logic        fetch_rst_out,
  output logic        matrix_valid_out,
  output logic        framebuffer_switch_out,
  output logic        framebuffer_clear_out,
  output logic [15:0] pixel_count_out,
  output logic [15:0] frame_count_out,
  output logic [15:0] overrun_count_out
);

  localparam int WAIT_W = $clog2(MATRIX_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUF, LOAD, RENDER} state_t;

  state_t                 state;
  logic [TIMER_WIDTH-1:0] timer;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [15:0]            pix_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Free-running frame timer; only gated by enable, never by the FSM.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timer                  <= '0;
      framebuffer_switch_out <= 1'b0;
      framebuffer_clear_out  <= 1'b0;
    end else if (!enable_in) begin
      timer                  <= '0;
      framebuffer_switch_out <= 1'b0;
      framebuffer_clear_out  <= 1'b0;
    end else if (timer == TIMER_WIDTH'(FRAME_PERIOD - 1)) begin
      timer                  <= '0;
      framebuffer_switch_out <= 1'b1;
      framebuffer_clear_out  <= 1'b1;
    end else begin
      timer                  <= timer + TIMER_WIDTH'(1);
      framebuffer_switch_out <= 1'b0;
      framebuffer_clear_out  <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      pix_cnt           <= '0;
      fetch_rst_out     <= 1'b1;
      matrix_valid_out  <= 1'b0;
      pixel_count_out   <= '0;
      frame_count_out   <= '0;
      overrun_count_out <= '0;
    end else begin
      matrix_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          fetch_rst_out <= 1'b1;
          if (enable_in) state <= WAIT_BUF;
        end
        WAIT_BUF: begin
          fetch_rst_out <= 1'b1;
          if (!enable_in) begin
            state <= IDLE;
          end else if (framebuffer_ready_in) begin
            matrix_valid_out <= 1'b1;
            wait_cnt         <= WAIT_W'(MATRIX_LATENCY);
            state            <= LOAD;
          end
        end
        // Counter runs down to 0 and the release happens one edge later, so fetch
        // leaves reset MATRIX_LATENCY+1 edges after the matrix load was launched.
        LOAD: begin
          if (wait_cnt == '0) begin
            fetch_rst_out   <= 1'b0;
            pix_cnt         <= '0;
            frame_count_out <= frame_count_out + 16'd1;
            state           <= RENDER;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        RENDER: begin
          if (!framebuffer_ready_in) begin
            pixel_count_out <= pixel_valid_in ? sat_inc16(pix_cnt) : pix_cnt;
            if (!pipeline_idle_in) overrun_count_out <= sat_inc16(overrun_count_out);
            fetch_rst_out <= 1'b1;
            state         <= WAIT_BUF;
          end else if (pixel_valid_in) begin
            pix_cnt <= sat_inc16(pix_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: timer pulses, frame vector table with a
// scoreboard of end-of-frame statistics, and hand sequences for LOAD/enable/reset corners.
module tb_frame_sequencer;

  localparam int FP  = 10;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n, enable, ready, pvalid, pidle;
  logic        fetch_rst, mvalid, fswitch, fclear;
  logic [15:0] pix_cnt, frm_cnt, ovr_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_frames = 16'd0;

  typedef struct {
    int          npix;
    bit          valid_on_fall;
    bit          idle;
    bit          noise;
    logic [15:0] exp_pix;
    logic [15:0] exp_ovr;
  } frame_vec_t;

  typedef struct {
    logic [15:0] pix;
    logic [15:0] ovr;
    logic [15:0] frames;
  } exp_t;

  frame_vec_t tbl[5];
  exp_t       sbq[$];

  frame_sequencer #(.FRAME_PERIOD(FP), .TIMER_WIDTH(22), .MATRIX_LATENCY(LAT)) dut (
    .clk_in                (clk),
    .rst_n_in              (rst_n),
    .enable_in             (enable),
    .framebuffer_ready_in  (ready),
    .pixel_valid_in        (pvalid),
    .pipeline_idle_in      (pidle),
    .fetch_rst_out         (fetch_rst),
    .matrix_valid_out      (mvalid),
    .framebuffer_switch_out(fswitch),
    .framebuffer_clear_out (fclear),
    .pixel_count_out       (pix_cnt),
    .frame_count_out       (frm_cnt),
    .overrun_count_out     (ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic end_frame(input bit vof, input bit idle, input logic [15:0] epix,
                           input logic [15:0] eovr);
    exp_t e;
    exp_t g;
    ready  = 1'b0;
    pvalid = vof;
    pidle  = idle;
    e.pix = epix; e.ovr = eovr; e.frames = exp_frames;
    sbq.push_back(e);
    step();
    if (sbq.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      g = sbq.pop_front();
      chk("pixel_count", {16'd0, pix_cnt}, {16'd0, g.pix});
      chk("overrun_count", {16'd0, ovr_cnt}, {16'd0, g.ovr});
      chk("frame_count_end", {16'd0, frm_cnt}, {16'd0, g.frames});
      chk("fetch_rst_end", {31'd0, fetch_rst}, 32'd1);
    end
    pvalid = 1'b0;
    pidle  = 1'b1;
  endtask

  // Launches a frame from WAIT_BUF and checks matrix pulse / release latency.
  task automatic start_frame(input bit noise);
    ready  = 1'b1;
    pvalid = noise;
    step();
    chk("mvalid_pulse", {31'd0, mvalid}, 32'd1);
    chk("fetch_rst_wait", {31'd0, fetch_rst}, 32'd1);
    for (int k = 1; k <= LAT + 1; k++) begin
      step();
      chk("mvalid_once", {31'd0, mvalid}, 32'd0);
      chk("fetch_rst_lat", {31'd0, fetch_rst}, (k <= LAT) ? 32'd1 : 32'd0);
      chk("frame_count_lat", {16'd0, frm_cnt},
          {16'd0, (k <= LAT) ? exp_frames : exp_frames + 16'd1});
    end
    exp_frames = exp_frames + 16'd1;
    pvalid = 1'b0;
  endtask

  task automatic run_frame(input frame_vec_t v);
    start_frame(v.noise);
    if (v.npix > 0) begin
      pvalid = 1'b1;
      for (int i = 0; i < v.npix; i++) step();
    end
    end_frame(v.valid_on_fall, v.idle, v.exp_pix, v.exp_ovr);
    step();
  endtask

  initial begin
    //           npix   vof  idle noise pix       ovr
    tbl[0] = '{37,    1'b1, 1'b1, 1'b0, 16'd38,   16'd0};
    tbl[1] = '{5,     1'b0, 1'b0, 1'b1, 16'd5,    16'd1};
    tbl[2] = '{0,     1'b1, 1'b0, 1'b0, 16'd1,    16'd2};
    tbl[3] = '{12,    1'b0, 1'b0, 1'b1, 16'd12,   16'd3};
    tbl[4] = '{70000, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'd3};

    rst_n = 1'b0; enable = 1'b0; ready = 1'b0; pvalid = 1'b0; pidle = 1'b1;
    #12;
    chk("rst_fetch_rst", {31'd0, fetch_rst}, 32'd1);
    chk("rst_mvalid", {31'd0, mvalid}, 32'd0);
    chk("rst_switch", {31'd0, fswitch}, 32'd0);
    chk("rst_clear", {31'd0, fclear}, 32'd0);
    chk("rst_pix", {16'd0, pix_cnt}, 32'd0);
    chk("rst_frames", {16'd0, frm_cnt}, 32'd0);
    chk("rst_ovr", {16'd0, ovr_cnt}, 32'd0);

    step();
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      chk("switch_period", {31'd0, fswitch}, (k % FP == 0) ? 32'd1 : 32'd0);
      chk("clear_period", {31'd0, fclear}, (k % FP == 0) ? 32'd1 : 32'd0);
    end

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    // Ready drops during LOAD: frame still enters RENDER, then closes with 0 pixels.
    ready = 1'b1;
    step();
    chk("load_drop_mvalid", {31'd0, mvalid}, 32'd1);
    ready = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) step();
    exp_frames = exp_frames + 16'd1;
    chk("load_drop_render", {31'd0, fetch_rst}, 32'd0);
    chk("load_drop_frames", {16'd0, frm_cnt}, {16'd0, exp_frames});
    end_frame(1'b0, 1'b1, 16'd0, 16'd3);
    step();

    // Enable dropped mid-frame: frame completes, then FSM parks in IDLE.
    start_frame(1'b0);
    enable = 1'b0;
    pvalid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    end_frame(1'b0, 1'b1, 16'd3, 16'd3);
    step();
    ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      chk("idle_no_switch", {31'd0, fswitch}, 32'd0);
      chk("idle_no_mvalid", {31'd0, mvalid}, 32'd0);
      chk("idle_fetch_rst", {31'd0, fetch_rst}, 32'd1);
    end
    ready  = 1'b0;
    enable = 1'b1;
    for (int k = 1; k <= FP; k++) begin
      step();
      chk("reenable_switch", {31'd0, fswitch}, (k == FP) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset in the middle of LOAD.
    ready = 1'b1;
    step();
    step();
    step();
    chk("preload_fetch_rst", {31'd0, fetch_rst}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fetch_rst", {31'd0, fetch_rst}, 32'd1);
    chk("arst_mvalid", {31'd0, mvalid}, 32'd0);
    chk("arst_switch", {31'd0, fswitch}, 32'd0);
    chk("arst_clear", {31'd0, fclear}, 32'd0);
    chk("arst_pix", {16'd0, pix_cnt}, 32'd0);
    chk("arst_frames", {16'd0, frm_cnt}, 32'd0);
    chk("arst_ovr", {16'd0, ovr_cnt}, 32'd0);
    chk("sb_drained", sbq.size(), 32'd0);
    step();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
